nv_blkbox_pipe_buffer: RTL
==========================

Name: nv_blkbox_pipe_buffer

Overview:
- Parametrised, retimed successor to the plain blackbox buffer.
- Carries a WIDTH-bit payload through DEPTH full-throughput skid stages with valid/ready flow control.
- Breaks long routes and combinational ready paths between partitions without losing bandwidth.
- DEPTH=0 degenerates to a pure wire for drop-in use.

Parameters:
- WIDTH, 32, payload width in bits (1..1024).
- DEPTH, 2, number of skid stages (0..8); 0 = combinational pass-through.
- CNT_W, 5, width of the occupancy output; must satisfy 2^CNT_W > 2*DEPTH.

Ports:
- nvdla_core_clk  input  1  core clock; all state updates on the rising edge.
- nvdla_core_rst  input  1  synchronous, active-high reset.
- din_pvld  input  1  upstream valid.
- din_prdy  output  1  upstream ready.
- din_pd  input  WIDTH  upstream payload.
- dout_pvld  output  1  downstream valid.
- dout_prdy  input  1  downstream ready.
- dout_pd  output  WIDTH  downstream payload.
- occupancy  output  CNT_W  number of entries currently held, 0..2*DEPTH.
- idle  output  1  high when occupancy==0 and din_pvld==0.

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset is synchronous and active-high on nvdla_core_rst, sampled on the rising edge.
- Transfer rule: a transfer occurs on an interface when pvld && prdy are high in the same cycle.
- Producer obligation: once pvld is raised, pvld and pd are held until the transfer. The block honours this on dout.
- DEPTH=0:
  - dout_pvld=din_pvld, din_prdy=dout_prdy, dout_pd=din_pd, occupancy=0, idle=!din_pvld.
  - No flops. Reset has no effect.
- DEPTH>=1: stages S0..S(DEPTH-1) in series. S0 faces din, S(DEPTH-1) faces dout. Each stage holds a main register (m_vld, m_pd) and a skid register (s_vld, s_pd).
- Stage ready and accept:
  - in_rdy = !s_vld, taken straight from a flop. No combinational path from dout_prdy to din_prdy.
  - acc = in_vld && in_rdy. drain = m_vld && out_rdy.
- Stage next state, evaluated per edge:
  - If !m_vld or drain: the main register loads the skid entry if s_vld (and s_vld clears, then s_vld=acc, s_pd=in_pd), else loads the input (m_vld=acc).
  - Otherwise, if acc: the skid register captures the input (s_vld=1).
  - Otherwise: both registers hold.
- Stage outputs: out_vld=m_vld, out_pd=m_pd.
- Ordering: strict FIFO order is preserved; no payload is dropped or duplicated.
- Throughput: one transfer per cycle sustained when dout_prdy is held high.
- Latency: a beat accepted at edge N appears on dout_pvld in cycle N+DEPTH (empty pipe, dout_prdy=1).
- Capacity: 2*DEPTH entries. With dout_prdy=0, din_prdy falls after exactly 2*DEPTH accepted beats.
- Occupancy: a registered sum of m_vld+s_vld over all stages. It is updated on the same edge as the state, so it reflects post-edge contents and changes by at most +1/-1 per cycle.
- Reset values: all m_vld and s_vld = 0, so dout_pvld=0, din_prdy=1 (DEPTH>=1), occupancy=0, idle=!din_pvld.
  - Payload registers are not reset. dout_pd is don't-care while dout_pvld=0.
- Reset mid-operation: all in-flight beats are discarded on the reset edge. No transfer is reported on that edge, even if pvld&&prdy.
- Simultaneous accept and drain at a stage with m_vld=1, s_vld=0: the main register takes the new beat and occupancy is unchanged.
- Full stage (s_vld=1) with downstream draining: the main register takes the skid beat and the skid register frees. in_rdy rises next cycle, so there is one bubble only at the full-to-draining transition.
- X-safety: din_pd may be X when din_pvld=0 without corrupting held state.
- Assertions:
  - dout_pvld never falls and dout_pd never changes while dout_pvld && !dout_prdy.
  - occupancy never exceeds 2*DEPTH.
  - Elaboration check: 2^CNT_W > 2*DEPTH.

Test Plan:
- Reset and idle: DEPTH=2, WIDTH=32. Hold nvdla_core_rst=1 for 3 cycles, then release -> dout_pvld=0, din_prdy=1, occupancy=0, idle=1 on every cycle with din_pvld=0.
- Latency and streaming: DEPTH=3, dout_prdy=1, drive 0x00000001..0x00000010 back-to-back -> first dout_pvld 3 cycles after first accept; 16 beats in order, one per cycle, no bubbles.
- Backpressure fill and drain: DEPTH=2, dout_prdy=0, drive 0xA0..0xA5 -> exactly 4 accepted (0xA0..0xA3), din_prdy=0 with occupancy=4. Then raise dout_prdy -> output 0xA0,0xA1,0xA2,0xA3,0xA4,0xA5 in order, and occupancy returns to 0.
- Random stalls: DEPTH=4, random din_pvld/dout_prdy at 50% each, 10000 beats of incrementing data -> scoreboard exact order match, protocol assertions clean, occupancy equals scoreboard count every cycle.
- Reset mid-flight: DEPTH=2, occupancy=3, assert nvdla_core_rst for 1 cycle with din_pvld=1 -> next cycle occupancy=0, dout_pvld=0, no held beats emerge afterwards.
- DEPTH=0 pass-through: WIDTH=8, din_pd=0x5A, din_pvld=1, toggle dout_prdy -> dout_pd=0x5A and dout_pvld=1 in the same cycle, din_prdy tracks dout_prdy combinationally, occupancy=0.

Source files
------------

// File: rtl/nv_blkbox_pipe_buffer.sv
// Valid/ready pipe buffer: DEPTH full-throughput skid stages between partitions.
// DEPTH=0 collapses to wires so the block can drop in where a plain buffer sat.
module nv_blkbox_pipe_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 5
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             din_pvld,
  output logic             din_prdy,
  input  logic [WIDTH-1:0] din_pd,
  output logic             dout_pvld,
  input  logic             dout_prdy,
  output logic [WIDTH-1:0] dout_pd,
  output logic [CNT_W-1:0] occupancy,
  output logic             idle
);

  if ((2 ** CNT_W) <= 2 * DEPTH) begin : g_cnt_w_check
    $error("nv_blkbox_pipe_buffer: CNT_W too narrow to count 2*DEPTH entries");
  end

  if (DEPTH == 0) begin : g_wire
    assign dout_pvld = din_pvld;
    assign din_prdy  = dout_prdy;
    assign dout_pd   = din_pd;
    assign occupancy = '0;
    assign idle      = !din_pvld;

    logic unused_clk_rst;
    assign unused_clk_rst = nvdla_core_clk ^ nvdla_core_rst;
  end else begin : g_pipe
    logic [DEPTH-1:0] m_vld;
    logic [DEPTH-1:0] s_vld;
    logic [DEPTH-1:0] in_vld;
    logic [DEPTH-1:0] out_rdy;
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] drain;
    logic [WIDTH-1:0] m_pd [DEPTH];
    logic [WIDTH-1:0] s_pd [DEPTH];
    logic [WIDTH-1:0] in_pd [DEPTH];
    logic [CNT_W-1:0] occ_q;

    // Stage k is fed by stage k-1 and throttled by the skid flag of stage k+1.
    always_comb begin
      in_vld[0]          = din_pvld;
      in_pd[0]           = din_pd;
      out_rdy[DEPTH-1]   = dout_prdy;
      for (int k = 1; k < DEPTH; k++) begin
        in_vld[k]    = m_vld[k-1];
        in_pd[k]     = m_pd[k-1];
        out_rdy[k-1] = !s_vld[k];
      end
      for (int k = 0; k < DEPTH; k++) begin
        acc[k]   = in_vld[k] && !s_vld[k];
        drain[k] = m_vld[k] && out_rdy[k];
      end
    end

    always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
        m_vld <= '0;
        s_vld <= '0;
        occ_q <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (!m_vld[k] || drain[k]) begin
            if (s_vld[k]) begin
              m_vld[k] <= 1'b1;
              s_vld[k] <= acc[k];
            end else begin
              m_vld[k] <= acc[k];
            end
          end else if (acc[k]) begin
            s_vld[k] <= 1'b1;
          end
        end
        // Inter-stage moves keep the total; only the two end interfaces change it.
        occ_q <= occ_q + CNT_W'(acc[0]) - CNT_W'(drain[DEPTH-1]);
      end
    end

    // Payload loads only on accept, so an X on din_pd while idle never lands in state.
    always_ff @(posedge nvdla_core_clk) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!m_vld[k] || drain[k]) begin
          if (s_vld[k]) begin
            m_pd[k] <= s_pd[k];
          end else if (acc[k]) begin
            m_pd[k] <= in_pd[k];
          end
        end else if (acc[k]) begin
          s_pd[k] <= in_pd[k];
        end
      end
    end

    assign din_prdy  = !s_vld[0];
    assign dout_pvld = m_vld[DEPTH-1];
    assign dout_pd   = m_pd[DEPTH-1];
    assign occupancy = occ_q;
    assign idle      = (occ_q == '0) && !din_pvld;

    a_dout_hold: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
      (dout_pvld && !dout_prdy) |=> (dout_pvld && $stable(dout_pd)));
    a_occ_max: assert property (@(posedge nvdla_core_clk)
      occupancy <= CNT_W'(2 * DEPTH));
  end

endmodule
